// File: rtl/inc_reg_bank_pkg.sv
// rtl/inc_reg_bank_pkg.sv - shared constants for the increment register bank
package inc_reg_bank_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int NREG       = 7;

  localparam int REG_ROW  = 0;
  localparam int REG_COL  = 1;
  localparam int REG_CURR = 2;
  localparam int REG_STA  = 3;
  localparam int REG_STB  = 4;
  localparam int REG_STC  = 5;
  localparam int REG_R1   = 6;

  localparam logic [2:0] RD_DIM = 3'd7;
endpackage

// File: rtl/inc_counter_cell.sv
// rtl/inc_counter_cell.sv - one counter register with clr > ld > inc priority and sticky wrap flag
module inc_counter_cell #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         ovf
);
  logic [W-1:0] r_q;
  logic         r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (ld) begin
      r_q   <= d;
    end else if (inc) begin
      r_q   <= r_q + W'(1);
      // a load leaves the flag alone; only clear or reset drops it
      if (&r_q) r_ovf <= 1'b1;
    end
  end

  assign q   = r_q;
  assign ovf = r_ovf;
endmodule

// File: rtl/inc_reg_bank.sv
// rtl/inc_reg_bank.sv - seven increment-capable registers, DIM compare flags and registered read port
module inc_reg_bank
  import inc_reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_ROW,
  input  logic              inc_COL,
  input  logic              inc_CURR,
  input  logic              inc_STA,
  input  logic              inc_STB,
  input  logic              inc_STC,
  input  logic              inc_R1,
  input  logic [NREG-1:0]   ld_sel,
  input  logic [NREG-1:0]   clr_sel,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              dim_ld,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] row_q,
  output logic [DATA_W-1:0] col_q,
  output logic [DATA_W-1:0] curr_q,
  output logic [DATA_W-1:0] sta_q,
  output logic [DATA_W-1:0] stb_q,
  output logic [DATA_W-1:0] stc_q,
  output logic [DATA_W-1:0] r1_q,
  output logic              row_last,
  output logic              col_last,
  output logic              curr_last,
  output logic [NREG-1:0]   ovf
);
  logic [NREG-1:0]   w_inc;
  logic [DATA_W-1:0] w_q [NREG];
  logic [DATA_W-1:0] w_dim_m1;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] r_dim;
  logic [DATA_W-1:0] r_bus_out;

  assign w_inc = {inc_R1, inc_STC, inc_STB, inc_STA, inc_CURR, inc_COL, inc_ROW};

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    inc_counter_cell #(.W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_sel[g]),
      .ld    (ld_sel[g]),
      .inc   (w_inc[g]),
      .d     (bus_in),
      .q     (w_q[g]),
      .ovf   (ovf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_dim <= '0;
    else if (dim_ld) r_dim <= bus_in;
  end

  // DIM=0 wraps to all-ones here, which is the intended terminal value
  assign w_dim_m1  = r_dim - DATA_W'(1);
  assign row_last  = (w_q[REG_ROW]  == w_dim_m1);
  assign col_last  = (w_q[REG_COL]  == w_dim_m1);
  assign curr_last = (w_q[REG_CURR] == w_dim_m1);

  always_comb begin
    w_rd = r_dim;
    for (int i = 0; i < NREG; i++) begin
      if (rd_sel == 3'(i)) w_rd = w_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_bus_out <= '0;
    else        r_bus_out <= w_rd;
  end

  assign bus_out = r_bus_out;
  assign row_q   = w_q[REG_ROW];
  assign col_q   = w_q[REG_COL];
  assign curr_q  = w_q[REG_CURR];
  assign sta_q   = w_q[REG_STA];
  assign stb_q   = w_q[REG_STB];
  assign stc_q   = w_q[REG_STC];
  assign r1_q    = w_q[REG_R1];
endmodule

// File: tb/tb_inc_reg_bank.sv
// tb/tb_inc_reg_bank.sv - directed self-checking bench for inc_reg_bank
module tb_inc_reg_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc_ROW, inc_COL, inc_CURR, inc_STA, inc_STB, inc_STC, inc_R1;
  logic [6:0]  ld_sel, clr_sel;
  logic [15:0] bus_in;
  logic        dim_ld;
  logic [2:0]  rd_sel;
  logic [15:0] bus_out, row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q;
  logic        row_last, col_last, curr_last;
  logic [6:0]  ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inc_reg_bank dut (
    .clk(clk), .rst_n(rst_n),
    .inc_ROW(inc_ROW), .inc_COL(inc_COL), .inc_CURR(inc_CURR), .inc_STA(inc_STA),
    .inc_STB(inc_STB), .inc_STC(inc_STC), .inc_R1(inc_R1),
    .ld_sel(ld_sel), .clr_sel(clr_sel), .bus_in(bus_in), .dim_ld(dim_ld),
    .rd_sel(rd_sel), .bus_out(bus_out),
    .row_q(row_q), .col_q(col_q), .curr_q(curr_q), .sta_q(sta_q),
    .stb_q(stb_q), .stc_q(stc_q), .r1_q(r1_q),
    .row_last(row_last), .col_last(col_last), .curr_last(curr_last),
    .ovf(ovf)
  );

  task automatic set_inc(input logic [6:0] v);
    {inc_R1, inc_STC, inc_STB, inc_STA, inc_CURR, inc_COL, inc_ROW} = v;
  endtask

  task automatic idle();
    set_inc(7'h00);
    ld_sel = '0; clr_sel = '0; dim_ld = 1'b0; bus_in = '0; rd_sel = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_inc(7'h7F);
    ld_sel = 7'h7F; bus_in = 16'h1234; dim_ld = 1'b1; rd_sel = 3'd7; clr_sel = '0;
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q} !== 112'd0) begin
      errors++; $display("FAIL reset_q got %h %h %h %h %h %h %h exp 0", row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q);
    end
    checks++;
    if (ovf !== 7'h00) begin errors++; $display("FAIL reset_ovf got %h exp 00", ovf); end
    checks++;
    if (bus_out !== 16'h0000) begin errors++; $display("FAIL reset_bus_out got %h exp 0000", bus_out); end
    idle();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus_out !== 16'h0000) begin errors++; $display("FAIL reset_dim got %h exp 0000", bus_out); end
  endtask

  task automatic test_priority();
    idle();
    ld_sel[1] = 1'b1; clr_sel[1] = 1'b1; inc_COL = 1'b1; bus_in = 16'h0055;
    step();
    checks++;
    if (col_q !== 16'h0000) begin errors++; $display("FAIL prio_clr got %h exp 0000", col_q); end
    clr_sel[1] = 1'b0;
    step();
    checks++;
    if (col_q !== 16'h0055) begin errors++; $display("FAIL prio_ld got %h exp 0055", col_q); end
    idle();
    step();
    checks++;
    if (col_q !== 16'h0055) begin errors++; $display("FAIL prio_hold got %h exp 0055", col_q); end
  endtask

  task automatic test_wrap();
    idle();
    ld_sel[3] = 1'b1; bus_in = 16'hFFFF;
    step();
    checks++;
    if (sta_q !== 16'hFFFF || ovf[3] !== 1'b0) begin errors++; $display("FAIL wrap_load got %h ovf %b exp ffff ovf 0", sta_q, ovf[3]); end
    idle(); inc_STA = 1'b1;
    step();
    checks++;
    if (sta_q !== 16'h0000 || ovf !== 7'b0001000) begin errors++; $display("FAIL wrap_inc got %h ovf %b exp 0000 ovf 0001000", sta_q, ovf); end
    idle(); ld_sel[3] = 1'b1; bus_in = 16'h0010;
    step();
    checks++;
    if (sta_q !== 16'h0010 || ovf[3] !== 1'b1) begin errors++; $display("FAIL wrap_ld_sticky got %h ovf %b exp 0010 ovf 1", sta_q, ovf[3]); end
    idle(); clr_sel[3] = 1'b1;
    step();
    checks++;
    if (sta_q !== 16'h0000 || ovf[3] !== 1'b0) begin errors++; $display("FAIL wrap_clr got %h ovf %b exp 0000 ovf 0", sta_q, ovf[3]); end
  endtask

  task automatic test_loop_flag();
    idle(); clr_sel[0] = 1'b1; dim_ld = 1'b1; bus_in = 16'd4;
    step();
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (row_last !== 1'b0) begin errors++; $display("FAIL loop_pre%0d got %b exp 0", i, row_last); end
      idle(); inc_ROW = 1'b1;
      step();
    end
    idle();
    checks++;
    if (row_q !== 16'd3 || row_last !== 1'b1) begin errors++; $display("FAIL loop_last got %h flag %b exp 0003 flag 1", row_q, row_last); end
    checks++;
    if (col_last !== 1'b0 || curr_last !== 1'b0) begin errors++; $display("FAIL loop_others got %b%b exp 00", col_last, curr_last); end
    dim_ld = 1'b1; bus_in = 16'd0;
    step();
    checks++;
    if (row_last !== 1'b0) begin errors++; $display("FAIL dim0_row3 got %b exp 0", row_last); end
    idle(); ld_sel[0] = 1'b1; bus_in = 16'hFFFF;
    step();
    checks++;
    if (row_last !== 1'b1) begin errors++; $display("FAIL dim0_allones got %b exp 1", row_last); end
  endtask

  task automatic test_simultaneous();
    idle(); clr_sel = 7'h7F; dim_ld = 1'b1; bus_in = 16'd9;
    step();
    idle(); set_inc(7'h7F);
    repeat (5) step();
    idle();
    checks++;
    if ({row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q} !== {7{16'd5}}) begin
      errors++; $display("FAIL simul_q got %h %h %h %h %h %h %h exp 0005", row_q, col_q, curr_q, sta_q, stb_q, stc_q, r1_q);
    end
    checks++;
    if (ovf !== 7'h00) begin errors++; $display("FAIL simul_ovf got %h exp 00", ovf); end
    rd_sel = 3'd6;
    step();
    checks++;
    if (bus_out !== 16'd5) begin errors++; $display("FAIL read_r1 got %h exp 0005", bus_out); end
    rd_sel = 3'd2; inc_CURR = 1'b1;
    step();
    checks++;
    if (bus_out !== 16'd5 || curr_q !== 16'd6) begin errors++; $display("FAIL read_old got %h curr %h exp 0005 curr 0006", bus_out, curr_q); end
    idle(); rd_sel = 3'd7;
    step();
    checks++;
    if (bus_out !== 16'd9) begin errors++; $display("FAIL read_dim got %h exp 0009", bus_out); end
  endtask

  task automatic test_mid_reset();
    idle(); inc_R1 = 1'b1;
    step(); step();
    checks++;
    if (r1_q !== 16'd7) begin errors++; $display("FAIL mid_pre got %h exp 0007", r1_q); end
    rst_n = 1'b0;
    step();
    checks++;
    if (r1_q !== 16'd0) begin errors++; $display("FAIL mid_rst got %h exp 0000", r1_q); end
    rst_n = 1'b1;
    step();
    checks++;
    if (r1_q !== 16'd1) begin errors++; $display("FAIL mid_resume got %h exp 0001", r1_q); end
    step();
    checks++;
    if (r1_q !== 16'd2 || stb_q !== 16'd0) begin errors++; $display("FAIL mid_count got %h stb %h exp 0002 stb 0000", r1_q, stb_q); end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_priority();
    test_wrap();
    test_loop_flag();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
